ps2_keycode_encoder: RTL and testbench

Converts the byte stream from the PS/2 keyboard receiver (make/break scan codes, set 2) into the 8-bit held-key bitmask consumed by the player-control keycode mapper. Tracks E0 (extended) and F0 (break) prefixes and holds one bit per game key while that key is down. Sits between the PS/2 byte receiver and the keycode mapper in the top-level game design.

---
 rtl/keycode_pkg.sv | 60 ++++++
 rtl/ps2_keycode_encoder.sv | 87 ++++++++
 tb/tb_ps2_keycode_encoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/keycode_pkg.sv
// keycode_pkg: PS/2 set-2 scan codes, game-key bit indices,
// prefix FSM states and the (code, extended) -> bit lookup.
package keycode_pkg;

  localparam int FB_JUMP_BIT  = 6;
  localparam int FB_LEFT_BIT  = 5;
  localparam int FB_RIGHT_BIT = 4;
  localparam int IG_JUMP_BIT  = 2;
  localparam int IG_LEFT_BIT  = 1;
  localparam int IG_RIGHT_BIT = 0;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BREAK,
    EXT_BREAK
  } ps2_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  function automatic key_hit_t map_code(
    input logic [7:0] code,
    input logic       ext
  );
    key_hit_t r;
    r.hit = 1'b0;
    r.idx = 3'd0;
    if (ext) begin
      case (code)
        SC_UP:    begin r.hit = 1'b1; r.idx = 3'(FB_JUMP_BIT);  end
        SC_LEFT:  begin r.hit = 1'b1; r.idx = 3'(FB_LEFT_BIT);  end
        SC_RIGHT: begin r.hit = 1'b1; r.idx = 3'(FB_RIGHT_BIT); end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_W:    begin r.hit = 1'b1; r.idx = 3'(IG_JUMP_BIT);  end
        SC_A:    begin r.hit = 1'b1; r.idx = 3'(IG_LEFT_BIT);  end
        SC_D:    begin r.hit = 1'b1; r.idx = 3'(IG_RIGHT_BIT); end
        default: ;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_keycode_encoder.sv
// ps2_keycode_encoder: scan-code byte stream -> held-key bitmask.
// Ports: Clk, Reset, scan_valid/scan_code, clear -> keycode, keycode_changed, prefix_pending.
module ps2_keycode_encoder
  import keycode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       clear,
  output logic [7:0] keycode,
  output logic       keycode_changed,
  output logic       prefix_pending
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    key_q, key_d;
  logic          chg_q;
  logic          ext, brk;
  key_hit_t      hit;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    ext     = (state_q == EXT) || (state_q == EXT_BREAK);
    brk     = (state_q == BREAK) || (state_q == EXT_BREAK);
    hit     = map_code(scan_code, ext);
    if (clear) begin
      state_d = IDLE;
      key_d   = '0;
      cnt_d   = '0;
    end else if (scan_valid) begin
      cnt_d = '0;
      unique case (1'b1)
        (scan_code == SC_EXT):
          state_d = brk ? EXT_BREAK : EXT;
        (scan_code == SC_BREAK):
          state_d = ext ? EXT_BREAK : BREAK;
        default: begin
          state_d = IDLE;
          if (hit.hit)
            key_d[hit.idx] = !brk;
          // error/overrun bytes only mean something outside a prefix
          else if (state_q == IDLE &&
                   (scan_code == SC_ERR0 ||
                    scan_code == SC_ERR1))
            key_d = '0;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      chg_q   <= (key_d != key_q);
    end
  end

  assign keycode         = key_q;
  assign keycode_changed = chg_q;
  assign prefix_pending  = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keycode_encoder.sv
// tb_ps2_keycode_encoder: directed + random byte stream against a
// prefix-flag reference model; per-cycle compare plus pinned literals.
module tb_ps2_keycode_encoder;

  localparam int T = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       clear;
  logic [7:0] keycode;
  logic       keycode_changed;
  logic       prefix_pending;

  ps2_keycode_encoder #(.TIMEOUT_CYCLES(T)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .scan_valid      (scan_valid),
    .scan_code       (scan_code),
    .clear           (clear),
    .keycode         (keycode),
    .keycode_changed (keycode_changed),
    .prefix_pending  (prefix_pending)
  );

  always #5 Clk = ~Clk;

  // reference model: pending prefix flags + idle-cycle age
  logic [7:0] m_key;
  logic       m_chg;
  logic       m_ext, m_brk;
  int         m_wait;

  bit         chk_en = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  int         lit_req = 0;
  int         lit_ack = 0;
  string      lit_name;
  logic [7:0] lit_key;
  logic       lit_chg, lit_pend;

  function automatic int key_bit(input logic [7:0] c, input bit e);
    if (e) begin
      case (c)
        8'h75:   return 6;
        8'h6B:   return 5;
        8'h74:   return 4;
        default: return -1;
      endcase
    end
    case (c)
      8'h1D:   return 2;
      8'h1C:   return 1;
      8'h23:   return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_key = 8'h00; m_chg = 1'b0;
    m_ext = 1'b0;  m_brk = 1'b0; m_wait = 0;
  endtask

  task automatic model(input logic v, input logic [7:0] c,
                       input logic clr);
    logic [7:0] old;
    int b;
    old = m_key;
    if (clr) begin
      m_key = 8'h00; m_ext = 0; m_brk = 0; m_wait = 0;
    end else if (v) begin
      m_wait = 0;
      if (c == 8'hE0) m_ext = 1;
      else if (c == 8'hF0) m_brk = 1;
      else begin
        b = key_bit(c, m_ext);
        if (b >= 0) m_key[b] = !m_brk;
        else if (!m_ext && !m_brk && (c == 8'h00 || c == 8'hFF))
          m_key = 8'h00;
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_wait++;
      if (m_wait == T) begin
        m_ext = 0; m_brk = 0; m_wait = 0;
      end
    end
    m_chg = (m_key != old);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      n_vec++;
      if (keycode !== m_key || keycode_changed !== m_chg ||
          prefix_pending !== (m_ext | m_brk)) begin
        n_bad++;
        $display("FAIL model t=%0t key=%h/%h chg=%b/%b pend=%b/%b",
                 $time, keycode, m_key, keycode_changed, m_chg,
                 prefix_pending, m_ext | m_brk);
      end
      n_vec++;
      if ((keycode[7] | keycode[3]) !== 1'b0) begin
        n_bad++;
        $display("FAIL unused_bits key=%h required bits7,3=0",
                 keycode);
      end
      if (lit_req != lit_ack) begin
        lit_ack = lit_req;
        n_vec++;
        if (keycode !== lit_key || keycode_changed !== lit_chg ||
            prefix_pending !== lit_pend) begin
          n_bad++;
          $display("FAIL %s key=%h/%h chg=%b/%b pend=%b/%b",
                   lit_name, keycode, lit_key, keycode_changed,
                   lit_chg, prefix_pending, lit_pend);
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [7:0] k,
                     input logic c, input logic p);
    lit_name = nm; lit_key = k; lit_chg = c; lit_pend = p;
    lit_req++;
  endtask

  task automatic step(input logic v, input logic [7:0] c,
                      input logic clr);
    @(negedge Clk);
    scan_valid = v; scan_code = c; clear = clr;
    @(posedge Clk);
    #1;
    model(v, c, clr);
    scan_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] pool [11];
    int r;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h1D,
             8'h1C, 8'h23, 8'h00, 8'hFF, 8'h5A};
    Reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
    clear = 1'b0;
    model_reset();
    chk_en = 1'b1;
    pin("reset_state", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1 Reset = 1'b0;

    send(8'h1D); pin("make_w", 8'h04, 1'b1, 1'b0);
    send(8'h1D); pin("typematic_w", 8'h04, 1'b0, 1'b0);
    send(8'hF0); send(8'h1D);
    pin("break_w", 8'h00, 1'b1, 1'b0);

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B);
    send(8'h23); pin("three_keys", 8'h61, 1'b1, 1'b0);
    send(8'hE0); pin("ext_pending", 8'h61, 1'b0, 1'b1);
    send(8'hF0); pin("extbrk_pending", 8'h61, 1'b0, 1'b1);
    send(8'h75); pin("break_up", 8'h21, 1'b1, 1'b0);

    send(8'hF0); send(8'h1C);
    pin("break_unheld", 8'h21, 1'b0, 1'b0);
    send(8'h75); pin("up_no_ext", 8'h21, 1'b0, 1'b0);
    send(8'hE0); send(8'h1D);
    pin("ext_w_nomatch", 8'h21, 1'b0, 1'b0);

    send(8'hE0);
    idle(T - 1); pin("timeout_not_yet", 8'h21, 1'b0, 1'b1);
    idle(1);     pin("timeout_expired", 8'h21, 1'b0, 1'b0);
    send(8'h74); pin("after_timeout", 8'h21, 1'b0, 1'b0);

    send(8'h1D); send(8'h1C); send(8'h23);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
    pin("hold_77", 8'h77, 1'b1, 1'b0);
    step(1'b1, 8'h1D, 1'b1);
    pin("clear_priority", 8'h00, 1'b1, 1'b0);
    send(8'h1C); send(8'hE0); send(8'h6B);
    send(8'hFF); pin("overrun_ff", 8'h00, 1'b1, 1'b0);

    send(8'hE0);
    #2 Reset = 1'b1;
    model_reset();
    pin("async_reset", 8'h00, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk); #1 Reset = 1'b0;
    send(8'h6B); pin("prefix_dropped", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)
        idle(T + $urandom_range(0, 2) - 1);
      else if (r < 5)
        step(1'b1, pool[$urandom_range(0, 10)], 1'b1);
      else if (r < 50)
        idle(1);
      else if (r < 55)
        send(8'($urandom_range(0, 255)));
      else
        send(pool[$urandom_range(0, 10)]);
    end

    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
